// File: rtl/noc_local_ni.sv
// noc_local_ni: network interface for the LOCAL port of one mesh router.
// Core words are buffered and injected as flits with precomputed routing sign
// bits; flits ejected to this node are buffered and delivered to the core.
// Ejected flits addressed elsewhere are consumed, dropped and flagged.

package global_params;
  localparam int DATA_WIDTH = 32;
  localparam int MESH_SIDE  = 4;
  localparam int CW         = $clog2(MESH_SIDE);
endpackage

module noc_local_ni
  import global_params::*;
#(
  parameter int X_COORD  = 0,
  parameter int Y_COORD  = 0,
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic [CW-1:0]         tx_dest_x,
  input  logic [CW-1:0]         tx_dest_y,
  output logic                  net_out_valid,
  input  logic                  net_out_ready,
  output logic [DATA_WIDTH-1:0] net_out_data,
  output logic [CW-1:0]         net_out_dest_x,
  output logic [CW-1:0]         net_out_dest_y,
  output logic                  net_out_s_delta_x,
  output logic                  net_out_s_delta_y,
  input  logic                  net_in_valid,
  output logic                  net_in_ready,
  input  logic [DATA_WIDTH-1:0] net_in_data,
  input  logic [CW-1:0]         net_in_dest_x,
  input  logic [CW-1:0]         net_in_dest_y,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic [15:0]           tx_count,
  output logic [15:0]           rx_count,
  output logic                  misroute
);

  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam logic [TAW:0]   TX_FULL = (TAW+1)'(TX_DEPTH);
  localparam logic [RAW:0]   RX_FULL = (RAW+1)'(RX_DEPTH);
  localparam logic [CW-1:0]  OWN_X   = CW'(X_COORD);
  localparam logic [CW-1:0]  OWN_Y   = CW'(Y_COORD);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [CW-1:0]         dest_x;
    logic [CW-1:0]         dest_y;
    logic                  s_delta_x;
    logic                  s_delta_y;
  } tx_entry_t;

  tx_entry_t             tx_mem_q [TX_DEPTH];
  tx_entry_t             tx_mem_d [TX_DEPTH];
  logic [TAW-1:0]        tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [TAW:0]          tx_occ_q, tx_occ_d;

  logic [DATA_WIDTH-1:0] rx_mem_q [RX_DEPTH];
  logic [DATA_WIDTH-1:0] rx_mem_d [RX_DEPTH];
  logic [RAW-1:0]        rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [RAW:0]          rx_occ_q, rx_occ_d;

  logic [15:0]           tx_count_q, tx_count_d;
  logic [15:0]           rx_count_q, rx_count_d;
  logic                  misroute_q, misroute_d;

  tx_entry_t             tx_new, tx_head;
  logic                  tx_push, tx_pop, rx_accept, rx_dest_ok, rx_push, rx_pop;

  // Ready/valid come from registered occupancy only, so neither side sees a
  // combinational path from the opposite handshake.
  assign tx_ready      = (tx_occ_q != TX_FULL);
  assign net_out_valid = (tx_occ_q != '0);
  assign net_in_ready  = (rx_occ_q != RX_FULL);
  assign rx_valid      = (rx_occ_q != '0);

  assign tx_push    = tx_valid && tx_ready;
  assign tx_pop     = net_out_valid && net_out_ready;
  assign rx_accept  = net_in_valid && net_in_ready;
  assign rx_dest_ok = (net_in_dest_x == OWN_X) && (net_in_dest_y == OWN_Y);
  assign rx_push    = rx_accept && rx_dest_ok;
  assign rx_pop     = rx_valid && rx_ready;

  // Sign bits are fixed when the word enters the FIFO; equal coordinates give 0.
  assign tx_new = '{data:      tx_data,
                    dest_x:    tx_dest_x,
                    dest_y:    tx_dest_y,
                    s_delta_x: (tx_dest_x < OWN_X),
                    s_delta_y: (tx_dest_y < OWN_Y)};

  // Head entry is masked to zero while empty so stale storage never leaks out.
  always_comb begin
    tx_head           = tx_mem_q[tx_rd_q];
    net_out_data      = net_out_valid ? tx_head.data      : '0;
    net_out_dest_x    = net_out_valid ? tx_head.dest_x    : '0;
    net_out_dest_y    = net_out_valid ? tx_head.dest_y    : '0;
    net_out_s_delta_x = net_out_valid && tx_head.s_delta_x;
    net_out_s_delta_y = net_out_valid && tx_head.s_delta_y;
    rx_data           = rx_valid ? rx_mem_q[rx_rd_q] : '0;
  end

  assign tx_count = tx_count_q;
  assign rx_count = rx_count_q;
  assign misroute = misroute_q;

  // Injection FIFO next state and network-side transfer counter.
  always_comb begin
    tx_mem_d   = tx_mem_q;
    tx_wr_d    = tx_wr_q;
    tx_rd_d    = tx_rd_q;
    tx_occ_d   = tx_occ_q;
    tx_count_d = tx_count_q;
    if (tx_push) begin
      tx_mem_d[tx_wr_q] = tx_new;
      tx_wr_d           = tx_wr_q + TAW'(1);
    end
    if (tx_pop) begin
      tx_rd_d    = tx_rd_q + TAW'(1);
      tx_count_d = tx_count_q + 16'd1;
    end
    case ({tx_push, tx_pop})
      2'b10:   tx_occ_d = tx_occ_q + (TAW+1)'(1);
      2'b01:   tx_occ_d = tx_occ_q - (TAW+1)'(1);
      default: tx_occ_d = tx_occ_q;
    endcase
  end

  // Ejection FIFO next state; misaddressed flits are consumed but only flagged.
  always_comb begin
    rx_mem_d   = rx_mem_q;
    rx_wr_d    = rx_wr_q;
    rx_rd_d    = rx_rd_q;
    rx_occ_d   = rx_occ_q;
    rx_count_d = rx_count_q;
    misroute_d = misroute_q | (rx_accept && !rx_dest_ok);
    if (rx_push) begin
      rx_mem_d[rx_wr_q] = net_in_data;
      rx_wr_d           = rx_wr_q + RAW'(1);
      rx_count_d        = rx_count_q + 16'd1;
    end
    if (rx_pop) begin
      rx_rd_d = rx_rd_q + RAW'(1);
    end
    case ({rx_push, rx_pop})
      2'b10:   rx_occ_d = rx_occ_q + (RAW+1)'(1);
      2'b01:   rx_occ_d = rx_occ_q - (RAW+1)'(1);
      default: rx_occ_d = rx_occ_q;
    endcase
  end

  // Control state: reset flushes both FIFOs and clears counters and flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
      tx_occ_q   <= '0;
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      rx_occ_q   <= '0;
      tx_count_q <= '0;
      rx_count_q <= '0;
      misroute_q <= 1'b0;
    end else begin
      tx_wr_q    <= tx_wr_d;
      tx_rd_q    <= tx_rd_d;
      tx_occ_q   <= tx_occ_d;
      rx_wr_q    <= rx_wr_d;
      rx_rd_q    <= rx_rd_d;
      rx_occ_q   <= rx_occ_d;
      tx_count_q <= tx_count_d;
      rx_count_q <= rx_count_d;
      misroute_q <= misroute_d;
    end
  end

  // FIFO storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    tx_mem_q <= tx_mem_d;
    rx_mem_q <= rx_mem_d;
  end

endmodule

// File: tb/tb_noc_local_ni.sv
// Testbench for noc_local_ni at node (2,1): directed stimulus with a
// queue-based scoreboard and independent output monitors.
module tb_noc_local_ni;
  import global_params::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  tx_valid, tx_ready;
  logic [DATA_WIDTH-1:0] tx_data;
  logic [CW-1:0]         tx_dest_x, tx_dest_y;
  logic                  net_out_valid, net_out_ready;
  logic [DATA_WIDTH-1:0] net_out_data;
  logic [CW-1:0]         net_out_dest_x, net_out_dest_y;
  logic                  net_out_s_delta_x, net_out_s_delta_y;
  logic                  net_in_valid, net_in_ready;
  logic [DATA_WIDTH-1:0] net_in_data;
  logic [CW-1:0]         net_in_dest_x, net_in_dest_y;
  logic                  rx_valid, rx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic [15:0]           tx_count, rx_count;
  logic                  misroute;

  always #5 clk = ~clk;

  noc_local_ni #(.X_COORD(2), .Y_COORD(1), .TX_DEPTH(4), .RX_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_dest_x(tx_dest_x), .tx_dest_y(tx_dest_y),
    .net_out_valid(net_out_valid), .net_out_ready(net_out_ready),
    .net_out_data(net_out_data), .net_out_dest_x(net_out_dest_x),
    .net_out_dest_y(net_out_dest_y), .net_out_s_delta_x(net_out_s_delta_x),
    .net_out_s_delta_y(net_out_s_delta_y),
    .net_in_valid(net_in_valid), .net_in_ready(net_in_ready),
    .net_in_data(net_in_data), .net_in_dest_x(net_in_dest_x),
    .net_in_dest_y(net_in_dest_y),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .tx_count(tx_count), .rx_count(rx_count), .misroute(misroute)
  );

  typedef struct packed {
    logic [DATA_WIDTH-1:0] d;
    logic [CW-1:0]         x;
    logic [CW-1:0]         y;
    logic                  sx;
    logic                  sy;
  } txexp_t;

  txexp_t                tx_q[$];
  logic [DATA_WIDTH-1:0] rx_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one word until accepted; expected flit (with hand-computed signs) is queued.
  task automatic send(input logic [DATA_WIDTH-1:0] d, input logic [CW-1:0] x,
                      input logic [CW-1:0] y, input logic sx, input logic sy);
    bit acc = 1'b0;
    int n = 0;
    tx_valid = 1'b1; tx_data = d; tx_dest_x = x; tx_dest_y = y;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = tx_ready;
      @(posedge clk);
      #1;
      n++;
    end
    tx_valid = 1'b0;
    if (acc) tx_q.push_back('{d, x, y, sx, sy});
    else begin
      n_cmp++; n_err++;
      $display("FAIL tx_accept_timeout: data %0h never accepted", d);
    end
  endtask

  // Present one ejected flit until accepted; own-addressed payloads are queued.
  task automatic eject(input logic [DATA_WIDTH-1:0] d, input logic [CW-1:0] x,
                       input logic [CW-1:0] y, input logic own, output bit acc);
    int n = 0;
    acc = 1'b0;
    net_in_valid = 1'b1; net_in_data = d; net_in_dest_x = x; net_in_dest_y = y;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = net_in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    net_in_valid = 1'b0;
    if (acc && own) rx_q.push_back(d);
    if (!acc) begin
      n_cmp++; n_err++;
      $display("FAIL rx_accept_timeout: data %0h never accepted", d);
    end
  endtask

  task automatic chk_reset(input string t);
    chk({t, "_tx_ready"},      tx_ready, 1);
    chk({t, "_net_in_ready"},  net_in_ready, 1);
    chk({t, "_net_out_valid"}, net_out_valid, 0);
    chk({t, "_rx_valid"},      rx_valid, 0);
    chk({t, "_tx_count"},      tx_count, 0);
    chk({t, "_rx_count"},      rx_count, 0);
    chk({t, "_misroute"},      misroute, 0);
    chk({t, "_out_data"},      net_out_data, 0);
    chk({t, "_out_dest"},      {net_out_dest_x, net_out_dest_y}, 0);
    chk({t, "_out_signs"},     {net_out_s_delta_x, net_out_s_delta_y}, 0);
  endtask

  // Network-side monitor: every flit transfer must match the queue head.
  always @(negedge clk) begin
    txexp_t e;
    if (rst && net_out_valid && net_out_ready) begin
      if (tx_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL tx_unexpected: flit %0h with nothing expected", net_out_data);
      end else begin
        e = tx_q.pop_front();
        chk("tx_data",  net_out_data, e.d);
        chk("tx_dest",  {net_out_dest_x, net_out_dest_y}, {e.x, e.y});
        chk("tx_signs", {net_out_s_delta_x, net_out_s_delta_y}, {e.sx, e.sy});
      end
    end
  end

  // Core-side monitor: every delivered word must match the queue head.
  always @(negedge clk) begin
    if (rst && rx_valid && rx_ready) begin
      if (rx_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL rx_unexpected: word %0h with nothing expected", rx_data);
      end else begin
        chk("rx_data", rx_data, rx_q.pop_front());
      end
    end
  end

  logic [DATA_WIDTH-1:0] w_d  [5] = '{32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'hB4};
  logic [CW-1:0]         w_x  [5] = '{2'd0, 2'd3, 2'd2, 2'd1, 2'd2};
  logic [CW-1:0]         w_y  [5] = '{2'd0, 2'd3, 2'd1, 2'd1, 2'd0};
  logic                  w_sx [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic                  w_sy [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    bit acc;
    rst = 1'b0; tx_valid = 1'b0; tx_data = '0; tx_dest_x = '0; tx_dest_y = '0;
    net_out_ready = 1'b0; net_in_valid = 1'b0; net_in_data = '0;
    net_in_dest_x = '0; net_in_dest_y = '0; rx_ready = 1'b0;
    tick(2);
    chk_reset("reset");
    rst = 1'b1;

    // Single injection toward (1,2) from (2,1): west sign set, south sign clear.
    net_out_ready = 1'b1;
    send(32'hA1, 2'd1, 2'd2, 1'b1, 1'b0);
    chk("t1_latency_valid", net_out_valid, 1);
    tick(1);
    chk("t1_tx_count", tx_count, 16'd1);
    chk("t1_drained", net_out_valid, 0);

    // Back-pressure: four words fill the FIFO, the fifth is held.
    net_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(w_d[i], w_x[i], w_y[i], w_sx[i], w_sy[i]);
    chk("t2_full_ready", tx_ready, 0);
    tx_valid = 1'b1; tx_data = w_d[4]; tx_dest_x = w_x[4]; tx_dest_y = w_y[4];
    for (int i = 0; i < 2; i++) begin
      tick(1);
      chk("t2_held_ready", tx_ready, 0);
      chk("t2_head_stable", net_out_data, 32'hB0);
    end
    net_out_ready = 1'b1;
    send(w_d[4], w_x[4], w_y[4], w_sx[4], w_sy[4]);
    tick(3);
    chk("t2_back_to_back_count", tx_count, 16'd6);
    chk("t2_drained", net_out_valid, 0);

    // Ejection to own node with core stalled, then delivery in order.
    for (int i = 0; i < 3; i++) begin
      eject(32'hC0 + i, 2'd2, 2'd1, 1'b1, acc);
      chk("t3_net_in_ready", net_in_ready, 1);
      if (i == 0) chk("t3_latency_rx_valid", rx_valid, 1);
    end
    chk("t3_rx_count", rx_count, 16'd3);
    chk("t3_rx_head", rx_data, 32'hC0);
    chk("t3_misroute_clear", misroute, 0);
    rx_ready = 1'b1;
    tick(3);
    chk("t3_rx_drained", rx_valid, 0);

    // Misaddressed flits are consumed, dropped and flagged stickily.
    eject(32'hD0, 2'd0, 2'd0, 1'b0, acc);
    chk("t4_accepted", acc, 1);
    chk("t4_no_rx_valid", rx_valid, 0);
    chk("t4_misroute", misroute, 1);
    chk("t4_rx_count", rx_count, 16'd3);
    eject(32'hD1, 2'd2, 2'd0, 1'b0, acc);
    tick(3);
    chk("t4_misroute_sticky", misroute, 1);
    chk("t4_rx_count_y", rx_count, 16'd3);
    chk("t4_net_in_ready", net_in_ready, 1);

    // Steady push+pop at occupancy 2 for ten cycles.
    net_out_ready = 1'b0;
    send(32'hE0, 2'd3, 2'd2, 1'b0, 1'b0);
    send(32'hE1, 2'd3, 2'd2, 1'b0, 1'b0);
    net_out_ready = 1'b1;
    for (int i = 0; i < 10; i++) send(32'hE2 + i, 2'd0, 2'd3, 1'b1, 1'b0);
    chk("t5_tx_count_10", tx_count, 16'd16);
    chk("t5_still_valid", net_out_valid, 1);
    chk("t5_tx_ready", tx_ready, 1);
    tick(2);
    chk("t5_tx_count_occ2", tx_count, 16'd18);
    chk("t5_drained", net_out_valid, 0);

    // Reset with three words buffered in each direction discards all of them.
    net_out_ready = 1'b0; rx_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(32'hF0 + i, 2'd1, 2'd0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) eject(32'h70 + i, 2'd2, 2'd1, 1'b1, acc);
    chk("t6_tx_buffered", net_out_valid, 1);
    chk("t6_rx_buffered", rx_valid, 1);
    tx_q.delete();
    rx_q.delete();
    rst = 1'b0;
    tick(1);
    chk_reset("t6");
    rst = 1'b1;
    net_out_ready = 1'b1; rx_ready = 1'b1;
    tick(3);
    chk("t6_no_stale_tx", net_out_valid, 0);
    chk("t6_no_stale_rx", rx_valid, 0);

    // Counter wrap: 65535 transfers reach 0xFFFF, one more wraps to 0.
    for (int i = 0; i < 65535; i++) send(i, 2'd2, 2'd2, 1'b0, 1'b0);
    tick(2);
    chk("wrap_ffff", tx_count, 16'hFFFF);
    send(32'h12345678, 2'd3, 2'd0, 1'b0, 1'b1);
    tick(2);
    chk("wrap_zero", tx_count, 16'h0000);

    chk("tx_queue_drained", tx_q.size(), 0);
    chk("rx_queue_drained", rx_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
